// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter on the open-drain clk/data pair.
// Inhibits the bus, issues request-to-send, shifts the byte with odd parity, captures the ACK and aborts on timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_err
);
    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, WAIT_IDLE, DONE} state_t;
    state_t        state_q, state_d;
    logic [2:0]    clk_s_q, data_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [8:0]    shift_q, shift_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          ready_q, ready_d, busy_q, busy_d;
    logic          done_q, done_d, ack_q, ack_d, err_q, err_d;
    logic          fall, data_s;
    assign fall = clk_s_q[2] & ~clk_s_q[1];
    assign data_s = data_s_q[2];
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_ready = ready_q;
    assign busy = busy_q;
    assign tx_done = done_q;
    assign tx_ack_ok = ack_q;
    assign tx_err = err_q;
    // Synchronizers reset high so a released bus never looks like a falling edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            clk_s_q   <= 3'b111;
            data_s_q  <= 3'b111;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_s_q   <= {clk_s_q[1:0], ps2_clk_in};
            data_s_q  <= {data_s_q[1:0], ps2_data_in};
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_d     = ack_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d  = {~^tx_data, tx_data};
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    cnt_d    = '0;
                    ack_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = RTS;
                end
            end
            RTS: begin
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                bitcnt_d = '0;
                state_d  = SEND;
            end
            SEND, WAIT_IDLE: begin
                cnt_d = fall ? '0 : cnt_q + CW'(1);
                if (fall) begin
                    bitcnt_d = (bitcnt_q == 4'd11) ? bitcnt_q : bitcnt_q + 4'd1;
                    // Shifting in ones makes the tenth fall release data as the stop bit.
                    if (state_q == SEND && bitcnt_q < 4'd10) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b1, shift_q[8:1]};
                    end else if (state_q == SEND) begin
                        ack_d   = ~data_s;
                        state_d = WAIT_IDLE;
                    end
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    ack_d     = 1'b0;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (state_q == WAIT_IDLE && clk_s_q[2] && data_s) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
